// File: rtl/c64_mem_pkg.sv
// Shared types and constants for the C64 core memory-port arbitration.
package c64_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    localparam int unsigned PORT_C64   = 0;
    localparam int unsigned PORT_IOCTL = 1;
    localparam int unsigned PORT_DRIVE = 2;
    localparam int unsigned PORT_DMA   = 3;

    // Round-robin successor over ports 1..n_req-1; port 0 is never a round-robin slot.
    function automatic int unsigned rr_advance(input int unsigned winner, input int unsigned n_req);
        return (winner + 1 >= n_req) ? 1 : winner + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector over ports 1..N_REQ-1, scanning from rr_ptr.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    output logic             valid,
    output logic [PW-1:0]    index
);

    int unsigned slot;

    always_comb begin
        valid = 1'b0;
        index = '0;
        slot  = 0;
        for (int unsigned k = 0; k < N_REQ - 1; k++) begin
            // Offset by N_REQ-1 so the rr_ptr-1 term cannot underflow.
            slot = ((32'(rr_ptr) + k + N_REQ - 2) % (N_REQ - 1)) + 1;
            if (!valid && req[PW'(slot)]) begin
                valid = 1'b1;
                index = PW'(slot);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Serialises the core's memory requesters onto the single SDRAM controller port.
module sdram_port_arbiter
    import c64_mem_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned AW           = 25,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned TIMEOUT      = 63
) (
    input  logic                clk32,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] din,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       dout,
    output logic [N_REQ-1:0]    err,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_din,
    input  logic [DW-1:0]       mem_dout,
    input  logic                mem_busy,
    input  logic                mem_ready
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    arb_state_t       state, state_nxt;
    logic [PW-1:0]    grant;
    logic [PW-1:0]    rr_ptr;
    logic [SW-1:0]    starve_cnt;
    logic [TW-1:0]    timer;

    logic             rr_valid;
    logic [PW-1:0]    rr_idx;
    logic             others;
    logic             p0_wins;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic             do_grant, do_issue, do_done, do_abort;
    logic             ce_nxt;
    logic [N_REQ-1:0] ack_nxt, err_nxt;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (rr_valid),
        .index  (rr_idx)
    );

    assign others  = |req[N_REQ-1:1];
    assign p0_wins = req[PORT_C64] && ((starve_cnt < SW'(STARVE_LIMIT)) || !others);

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        if (p0_wins) begin
            pick_valid = 1'b1;
            pick_idx   = PW'(PORT_C64);
        end else if (rr_valid) begin
            pick_valid = 1'b1;
            pick_idx   = rr_idx;
        end
    end

    // The ack/err cycle is spent in IDLE without sampling req, so a held req is not re-granted.
    assign do_grant = (state == IDLE) && (ack == '0) && (err == '0) && pick_valid;
    assign do_issue = (state == ISSUE) && !mem_busy;
    assign do_done  = (state == WAIT) && mem_ready;
    assign do_abort = (state == WAIT) && !mem_ready && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk32) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (do_grant) state_nxt = ISSUE;
            ISSUE:   if (do_issue) state_nxt = WAIT;
            WAIT:    if (do_done || do_abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ce_nxt  = do_issue;
        ack_nxt = '0;
        err_nxt = '0;
        if (do_done)  ack_nxt[grant] = 1'b1;
        if (do_abort) err_nxt[grant] = 1'b1;
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            ack        <= '0;
            err        <= '0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            dout       <= '0;
            grant      <= '0;
            rr_ptr     <= PW'(1);
            starve_cnt <= '0;
            timer      <= '0;
        end else begin
            ack    <= ack_nxt;
            err    <= err_nxt;
            mem_ce <= ce_nxt;

            if (do_grant) begin
                grant    <= pick_idx;
                mem_we   <= we[pick_idx];
                mem_addr <= addr[32'(pick_idx) * AW +: AW];
                mem_din  <= din[32'(pick_idx) * DW +: DW];
                if (pick_idx != PW'(PORT_C64))
                    rr_ptr <= PW'(rr_advance(32'(pick_idx), N_REQ));
            end

            if (do_issue)
                timer <= '0;
            else if (state == WAIT)
                timer <= timer + TW'(1);

            if (do_done && !mem_we)
                dout <= mem_dout;

            if (!others)
                starve_cnt <= '0;
            else if (do_grant) begin
                if (pick_idx != PW'(PORT_C64))
                    starve_cnt <= '0;
                else if (starve_cnt < SW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a simple SDRAM controller responder.
module tb_sdram_port_arbiter;
    import c64_mem_pkg::*;

    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 8;

    logic            clk32 = 1'b0;
    logic            reset;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] din;
    logic [N-1:0]    ack, err;
    logic [DW-1:0]   dout;
    logic            mem_ce, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   mem_dout;
    logic            mem_busy, mem_ready;

    sdram_port_arbiter #(
        .N_REQ        (N),
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (8),
        .TIMEOUT      (63)
    ) dut (
        .clk32     (clk32),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .ack       (ack),
        .dout      (dout),
        .err       (err),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_busy  (mem_busy),
        .mem_ready (mem_ready)
    );

    always #5 clk32 = ~clk32;

    int cyc = 0;
    always @(posedge clk32) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         port;
        bit         is_err;
        bit         chk_data;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [7:0] mem_fn(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hE0;
    endfunction

    // Controller model: answers each mem_ce with mem_ready after resp_delay cycles.
    int   resp_delay = 4;
    bit   resp_never = 1'b0;
    int   resp_cnt   = 0;
    int   rdy_cyc    = 0;
    int   ce_total   = 0;
    logic prev_ce    = 1'b0;

    initial begin
        mem_ready = 1'b0;
        mem_dout  = '0;
        forever begin
            @(negedge clk32);
            mem_ready = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_dout  = mem_fn(mem_addr);
                    rdy_cyc   = cyc;
                end
            end
            if (mem_ce === 1'b1) begin
                ce_total++;
                checks++;
                if (prev_ce === 1'b1) begin
                    errors++;
                    $display("FAIL ce_pulse: mem_ce=1 for a second cycle, expected 0");
                end
                if (!resp_never) resp_cnt = resp_delay;
            end
            if ((ack | err) !== '0) begin
                checks++;
                if ($countones({ack, err}) != 1) begin
                    errors++;
                    $display("FAIL onehot: ack=%b err=%b, expected exactly one bit", ack, err);
                end
            end
            prev_ce = mem_ce;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_event(input int budget, output bit got, output logic [N-1:0] a, output logic [N-1:0] e);
        got = 1'b0; a = '0; e = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk32);
            if ((ack | err) !== '0) begin
                got = 1'b1; a = ack; e = err;
                return;
            end
        end
    endtask

    task automatic wait_ce(input int budget, output bit got, output int at);
        got = 1'b0; at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk32);
            if (mem_ce === 1'b1) begin
                got = 1'b1; at = cyc;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk32);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; we = '0; addr = '0; din = '0; mem_busy = 1'b0;
        repeat (3) @(negedge clk32);
        reset = 1'b0;
        checks++; if (ack !== '0)      begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (err !== '0)      begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", mem_ce); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_din !== '0)  begin errors++; $display("FAIL reset_din: got %h expected 0", mem_din); end
        checks++; if (dout !== '0)     begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
        checks++; if (dut.state !== IDLE)   begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
        checks++; if (dut.rr_ptr !== 2'd1)  begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 1", dut.rr_ptr); end
        checks++; if (dut.starve_cnt !== '0) begin errors++; $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt); end
    endtask

    task automatic test_single_read();
        bit got; int ce_cyc; int req_cyc; logic [N-1:0] a, e; exp_t x;
        exp_q.push_back('{2, 1'b0, 1'b1, 8'hA5});
        addr[2*AW +: AW] = 25'h012345;
        we[2]   = 1'b0;
        req[2]  = 1'b1;
        req_cyc = cyc;
        wait_ce(20, got, ce_cyc);
        checks++; if (!got) begin errors++; $display("FAIL read_ce: no mem_ce within 20 cycles, expected one"); end
        checks++; if (ce_cyc - req_cyc != 2) begin errors++; $display("FAIL read_ce_latency: got %0d expected 2", ce_cyc - req_cyc); end
        checks++; if (mem_addr !== 25'h012345) begin errors++; $display("FAIL read_addr: got %h expected 0012345", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL read_we: got %b expected 0", mem_we); end
        wait_event(40, got, a, e);
        req[2] = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL read_ack: no ack within 40 cycles, expected ack[2]");
        end else begin
            x = exp_q.pop_front();
            if (a !== 4'(1 << x.port) || e !== '0 || dout !== x.data) begin
                errors++;
                $display("FAIL read_ack: ack=%b err=%b dout=%h, expected ack=%b err=0000 dout=%h", a, e, dout, 4'(1 << x.port), x.data);
            end
            checks++; if (cyc != rdy_cyc + 1) begin errors++; $display("FAIL read_ack_latency: got %0d expected 1", cyc - rdy_cyc); end
        end
        @(negedge clk32);
        checks++; if (ack !== '0) begin errors++; $display("FAIL read_ack_width: got %b expected 0", ack); end
    endtask

    task automatic test_round_robin();
        bit got; int ce_before; logic [N-1:0] a, e; exp_t x;
        apply_reset();
        for (int p = 1; p < N; p++) begin
            addr[p*AW +: AW] = AW'(32'h100 + p * 16);
            we[p] = 1'b0;
        end
        for (int r = 0; r < 2; r++)
            for (int p = 1; p < N; p++)
                exp_q.push_back('{p, 1'b0, 1'b1, mem_fn(AW'(32'h100 + p * 16))});
        req = 4'b1110;
        for (int k = 0; k < 6; k++) begin
            wait_event(60, got, a, e);
            if (k == 5) req = '0;
            checks++;
            if (!got) begin
                errors++; $display("FAIL rr_order: grant %0d timed out, expected an ack", k);
                req = '0;
                break;
            end
            x = exp_q.pop_front();
            if (a !== 4'(1 << x.port) || e !== '0 || dout !== x.data) begin
                errors++;
                $display("FAIL rr_order: grant %0d ack=%b dout=%h, expected ack=%b dout=%h", k, a, dout, 4'(1 << x.port), x.data);
            end
            @(negedge clk32);
            checks++; if (ack !== '0) begin errors++; $display("FAIL rr_ack_width: got %b expected 0", ack); end
        end
        ce_before = ce_total;
        repeat (20) @(negedge clk32);
        checks++; if (ce_total != ce_before) begin errors++; $display("FAIL rr_idle: got %0d extra mem_ce, expected 0", ce_total - ce_before); end
    endtask

    task automatic test_starvation();
        bit got; logic [N-1:0] a, e; exp_t x;
        apply_reset();
        addr[0*AW +: AW] = 25'h000200; we[0] = 1'b0;
        addr[3*AW +: AW] = 25'h000300; we[3] = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back('{0, 1'b0, 1'b1, mem_fn(25'h000200)});
        exp_q.push_back('{3, 1'b0, 1'b1, mem_fn(25'h000300)});
        exp_q.push_back('{0, 1'b0, 1'b1, mem_fn(25'h000200)});
        req = 4'b1001;
        for (int k = 0; k < 10; k++) begin
            wait_event(60, got, a, e);
            checks++;
            if (!got) begin
                errors++; $display("FAIL starve_order: grant %0d timed out, expected an ack", k);
                req = '0;
                break;
            end
            x = exp_q.pop_front();
            if (a !== 4'(1 << x.port) || e !== '0 || dout !== x.data) begin
                errors++;
                $display("FAIL starve_order: grant %0d ack=%b dout=%h, expected ack=%b dout=%h", k, a, dout, 4'(1 << x.port), x.data);
            end
            if (k == 7) begin
                checks++; if (dut.starve_cnt !== 4'd8) begin errors++; $display("FAIL starve_sat: got %0d expected 8", dut.starve_cnt); end
            end
            if (k == 8) begin
                req[3] = 1'b0;
                checks++; if (dut.starve_cnt !== '0) begin errors++; $display("FAIL starve_clear: got %0d expected 0", dut.starve_cnt); end
            end
            if (k == 9) req = '0;
        end
    endtask

    task automatic test_busy();
        bit got; int busy_ce; logic [DW-1:0] dout_before; logic [N-1:0] a, e; exp_t x;
        mem_busy = 1'b1;
        addr[1*AW +: AW] = 25'h0ABCDE;
        din[1*DW +: DW]  = 8'h3C;
        we[1]  = 1'b1;
        dout_before = dout;
        exp_q.push_back('{1, 1'b0, 1'b0, 8'h00});
        req[1] = 1'b1;
        busy_ce = 0;
        repeat (12) begin
            @(negedge clk32);
            if (mem_ce === 1'b1) busy_ce++;
        end
        checks++; if (busy_ce != 0) begin errors++; $display("FAIL busy_no_ce: got %0d pulses expected 0", busy_ce); end
        checks++; if (dut.state !== ISSUE) begin errors++; $display("FAIL busy_state: got %0d expected ISSUE", dut.state); end
        mem_busy = 1'b0;
        @(negedge clk32);
        checks++; if (mem_ce !== 1'b1) begin errors++; $display("FAIL busy_ce_rise: got %b expected 1", mem_ce); end
        checks++;
        if (mem_we !== 1'b1 || mem_din !== 8'h3C || mem_addr !== 25'h0ABCDE) begin
            errors++; $display("FAIL busy_write_cmd: we=%b din=%h addr=%h expected 1 3c 0abcde", mem_we, mem_din, mem_addr);
        end
        @(negedge clk32);
        checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL busy_ce_width: got %b expected 0", mem_ce); end
        wait_event(40, got, a, e);
        req[1] = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL busy_ack: no ack within 40 cycles, expected ack[1]");
        end else begin
            x = exp_q.pop_front();
            if (a !== 4'(1 << x.port) || e !== '0) begin errors++; $display("FAIL busy_ack: ack=%b err=%b expected ack=%b", a, e, 4'(1 << x.port)); end
            checks++; if (dout !== dout_before) begin errors++; $display("FAIL write_dout_hold: got %h expected %h", dout, dout_before); end
        end
    endtask

    task automatic test_timeout();
        bit got; int ce_cyc; logic [N-1:0] a, e; exp_t x;
        resp_never = 1'b1;
        addr[2*AW +: AW] = 25'h007777; we[2] = 1'b0;
        exp_q.push_back('{2, 1'b1, 1'b0, 8'h00});
        req[2] = 1'b1;
        wait_ce(20, got, ce_cyc);
        checks++; if (!got) begin errors++; $display("FAIL timeout_ce: no mem_ce within 20 cycles, expected one"); end
        wait_event(100, got, a, e);
        req[2] = 1'b0;
        resp_never = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL timeout_err: no err within 100 cycles, expected err[2]");
        end else begin
            x = exp_q.pop_front();
            if (e !== 4'(1 << x.port) || a !== '0) begin errors++; $display("FAIL timeout_err: ack=%b err=%b expected ack=0000 err=%b", a, e, 4'(1 << x.port)); end
            checks++; if (cyc - ce_cyc != 63) begin errors++; $display("FAIL timeout_latency: got %0d expected 63", cyc - ce_cyc); end
        end
        addr[1*AW +: AW] = 25'h004242; we[1] = 1'b0;
        exp_q.push_back('{1, 1'b0, 1'b1, mem_fn(25'h004242)});
        req[1] = 1'b1;
        wait_event(60, got, a, e);
        req[1] = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL timeout_recover: no ack within 60 cycles, expected ack[1]");
        end else begin
            x = exp_q.pop_front();
            if (a !== 4'(1 << x.port) || e !== '0 || dout !== x.data) begin
                errors++; $display("FAIL timeout_recover: ack=%b err=%b dout=%h expected ack=%b dout=%h", a, e, dout, 4'(1 << x.port), x.data);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got; int ce_cyc; int stray; int ce_before;
        resp_delay = 6;
        addr[3*AW +: AW] = 25'h001357; we[3] = 1'b0;
        req[3] = 1'b1;
        wait_ce(20, got, ce_cyc);
        checks++; if (!got) begin errors++; $display("FAIL rstmid_ce: no mem_ce within 20 cycles, expected one"); end
        repeat (2) @(negedge clk32);
        reset = 1'b1;
        req   = '0;
        @(negedge clk32);
        reset = 1'b0;
        stray = 0;
        ce_before = ce_total;
        repeat (15) begin
            @(negedge clk32);
            if ((ack | err) !== '0) stray++;
        end
        resp_delay = 4;
        checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_no_ack: got %0d ack/err cycles expected 0", stray); end
        checks++; if (ce_total != ce_before) begin errors++; $display("FAIL rstmid_no_ce: got %0d mem_ce expected 0", ce_total - ce_before); end
        checks++;
        if (mem_addr !== '0 || mem_din !== '0 || mem_we !== 1'b0 || dout !== '0) begin
            errors++; $display("FAIL rstmid_outputs: addr=%h din=%h we=%b dout=%h expected all 0", mem_addr, mem_din, mem_we, dout);
        end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected IDLE", dut.state); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_starvation();
        test_busy();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
